stack_engine: RTL and testbench

- Parametrised LIFO stack engine with a built-in ALU and a peek cursor.
- Successor to the per-cell output selector: the whole stack array, pointer and op decode live in one block.
- Executes one command per cycle: push, pop, pop-math, swap, cursor prev/next, clear.
- Sits between the command FSM and the display/readout logic. Exposes top-of-stack, second entry, cursor peek and status flags.

---
 rtl/stack_pkg.sv | 23 ++
 rtl/stack_alu.sv | 28 ++
 rtl/stack_engine.sv | 175 +++++++++++++++++
 tb/tb_stack_engine.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared opcode and ALU-function encodings for the
// stack engine and its helpers.
package stack_pkg;

  typedef enum logic [2:0] {
    CMD_NOP      = 3'd0,
    CMD_PUSH     = 3'd1,
    CMD_POP      = 3'd2,
    CMD_MATH     = 3'd3,
    CMD_SWAP     = 3'd4,
    CMD_CUR_PREV = 3'd5,
    CMD_CUR_NEXT = 3'd6,
    CMD_CLEAR    = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    MATH_ADD = 2'd0,
    MATH_SUB = 2'd1,
    MATH_AND = 2'd2,
    MATH_XOR = 2'd3
  } math_e;

endpackage

// File: rtl/stack_alu.sv
// Combinational two-operand ALU: r = a OP b,
// arithmetic wraps modulo 2^WIDTH.
import stack_pkg::*;

module stack_alu #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       math_sel,
  output logic [WIDTH-1:0] r
);

  math_e op;
  assign op = math_e'(math_sel);

  always_comb begin
    r = '0;
    unique case (op)
      MATH_ADD: r = a + b;
      MATH_SUB: r = a - b;
      MATH_AND: r = a & b;
      MATH_XOR: r = a ^ b;
      default:  r = '0;
    endcase
  end

endmodule

// File: rtl/stack_engine.sv
// LIFO stack with built-in ALU, peek cursor and
// registered pop/err pulses; one command per cycle.
import stack_pkg::*;

module stack_engine #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  input  logic [1:0]       math_sel,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [WIDTH-1:0] peek,
  output logic [CW-1:0]    cursor,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    cursor_q, cursor_d;
  logic             pop_valid_q, pop_valid_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic             err_q, err_d;

  logic [AW-1:0]    top_idx, sec_idx, cur_idx;
  logic [WIDTH-1:0] alu_r;
  logic             has2;

  logic             wr0_en, wr1_en;
  logic [AW-1:0]    wr0_idx, wr1_idx;
  logic [WIDTH-1:0] wr0_data, wr1_data;

  cmd_e op;
  assign op = cmd_e'(cmd);

  assign top_idx = AW'(count_q - CW'(1));
  assign sec_idx = AW'(count_q - CW'(2));
  assign cur_idx = AW'(cursor_q);
  assign has2    = (count_q >= CW'(2));

  // Gating by count hides stale entries left behind by CLEAR.
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign top    = empty ? '0 : mem_q[top_idx];
  assign second = has2  ? mem_q[sec_idx] : '0;
  assign peek   = empty ? '0 : mem_q[cur_idx];

  assign cursor    = cursor_q;
  assign count     = count_q;
  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_data_q;
  assign err       = err_q;

  stack_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a       (second),
    .b       (top),
    .math_sel(math_sel),
    .r       (alu_r)
  );

  always_comb begin
    count_d     = count_q;
    cursor_d    = cursor_q;
    pop_valid_d = 1'b0;
    pop_data_d  = pop_data_q;
    err_d       = 1'b0;
    wr0_en      = 1'b0;
    wr0_idx     = top_idx;
    wr0_data    = push_data;
    wr1_en      = 1'b0;
    wr1_idx     = sec_idx;
    wr1_data    = top;
    if (cmd_valid) begin
      unique case (op)
        CMD_PUSH: begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_idx  = AW'(count_q);
            wr0_data = push_data;
            count_d  = count_q + CW'(1);
          end
        end
        CMD_POP: begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            pop_data_d  = top;
            pop_valid_d = 1'b1;
            count_d     = count_q - CW'(1);
          end
        end
        CMD_MATH: begin
          if (!has2) begin
            err_d = 1'b1;
          end else begin
            wr1_en   = 1'b1;
            wr1_data = alu_r;
            count_d  = count_q - CW'(1);
          end
        end
        CMD_SWAP: begin
          if (!has2) begin
            err_d = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_data = second;
            wr1_en   = 1'b1;
            wr1_data = top;
          end
        end
        CMD_CUR_PREV: begin
          if (cursor_q != '0)
            cursor_d = cursor_q - CW'(1);
        end
        CMD_CUR_NEXT: begin
          if (!empty && cursor_q < top_idx_cw())
            cursor_d = cursor_q + CW'(1);
        end
        CMD_CLEAR: begin
          count_d  = '0;
          cursor_d = '0;
        end
        default: ;
      endcase
    end
    // Keep the cursor inside the occupied range after any shrink.
    if (count_d == '0)
      cursor_d = '0;
    else if (cursor_d > count_d - CW'(1))
      cursor_d = count_d - CW'(1);
  end

  function automatic logic [CW-1:0] top_idx_cw();
    return count_q - CW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      cursor_q    <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      count_q     <= count_d;
      cursor_q    <= cursor_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
      err_q       <= err_d;
      if (wr0_en)
        mem_q[wr0_idx] <= wr0_data;
      if (wr1_en)
        mem_q[wr1_idx] <= wr1_data;
    end
  end

endmodule

// File: tb/tb_stack_engine.sv
// Directed bench for stack_engine: hand-computed
// expectations checked with immediate assertions.
module tb_stack_engine;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] PUSH = 3'd1;
  localparam logic [2:0] POP  = 3'd2;
  localparam logic [2:0] MATH = 3'd3;
  localparam logic [2:0] SWAP = 3'd4;
  localparam logic [2:0] PREV = 3'd5;
  localparam logic [2:0] NEXT = 3'd6;
  localparam logic [2:0] CLR  = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic [2:0]       cmd;
  logic [1:0]       math_sel;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] top, second, peek;
  logic [CW-1:0]    cursor, count;
  logic             full, empty, pop_valid, err;
  logic [WIDTH-1:0] pop_data;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] vals [8];

  always #5 clk = ~clk;

  stack_engine #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .math_sel (math_sel),
    .push_data(push_data),
    .top      (top),
    .second   (second),
    .peek     (peek),
    .cursor   (cursor),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .pop_valid(pop_valid),
    .pop_data (pop_data),
    .err      (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [2:0] c,
                        input logic [1:0] m,
                        input logic [WIDTH-1:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    math_sel  = m;
    push_data = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd       = NOP;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd       = NOP;
    math_sel  = 2'd0;
    push_data = '0;
    vals = '{4'h1, 4'h4, 4'h7, 4'hA,
             4'hD, 4'h0, 4'h3, 4'h6};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_cursor", 32'(cursor), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_top", 32'(top), 0);
    chk("rst_popv", 32'(pop_valid), 0);
    chk("rst_popd", 32'(pop_data), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_cmd(PUSH, 2'd0, 4'h3);
    do_cmd(PUSH, 2'd0, 4'h5);
    chk("p35_count", 32'(count), 2);
    chk("p35_top", 32'(top), 5);
    chk("p35_second", 32'(second), 3);
    do_cmd(MATH, 2'd0, 4'h0);
    chk("add_count", 32'(count), 1);
    chk("add_top", 32'(top), 8);
    chk("add_err", 32'(err), 0);
    do_cmd(CLR, 2'd0, 4'h0);

    do_cmd(PUSH, 2'd0, 4'h2);
    do_cmd(PUSH, 2'd0, 4'h7);
    do_cmd(MATH, 2'd1, 4'h0);
    chk("sub_wrap_top", 32'(top), 32'hB);
    chk("sub_count", 32'(count), 1);
    do_cmd(PUSH, 2'd0, 4'hF);
    do_cmd(PUSH, 2'd0, 4'h3);
    do_cmd(MATH, 2'd0, 4'h0);
    chk("add_wrap_top", 32'(top), 32'h2);
    chk("add_wrap_second", 32'(second), 32'hB);
    do_cmd(PUSH, 2'd0, 4'h6);
    do_cmd(MATH, 2'd2, 4'h0);
    chk("and_top", 32'(top), 32'h2);
    do_cmd(PUSH, 2'd0, 4'h7);
    do_cmd(MATH, 2'd3, 4'h0);
    chk("xor_top", 32'(top), 32'h5);
    do_cmd(CLR, 2'd0, 4'h0);
    chk("clr_empty", 32'(empty), 1);

    for (int i = 0; i < 8; i++)
      do_cmd(PUSH, 2'd0, vals[i]);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 8);
    do_cmd(PUSH, 2'd0, 4'h9);
    chk("ovf_err", 32'(err), 1);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_top", 32'(top), 32'h6);
    for (int i = 7; i >= 0; i--) begin
      do_cmd(POP, 2'd0, 4'h0);
      chk($sformatf("pop%0d_data", i),
          32'(pop_data), 32'(vals[i]));
      chk($sformatf("pop%0d_valid", i),
          32'(pop_valid), 1);
    end
    chk("drain_empty", 32'(empty), 1);
    @(posedge clk);
    #1;
    chk("idle_popv", 32'(pop_valid), 0);
    do_cmd(POP, 2'd0, 4'h0);
    chk("udf_err", 32'(err), 1);
    chk("udf_popv", 32'(pop_valid), 0);
    chk("udf_count", 32'(count), 0);

    do_cmd(PUSH, 2'd0, 4'h1);
    do_cmd(PUSH, 2'd0, 4'h2);
    do_cmd(PUSH, 2'd0, 4'h3);
    repeat (5) do_cmd(NEXT, 2'd0, 4'h0);
    chk("next_cursor", 32'(cursor), 2);
    chk("next_peek", 32'(peek), 3);
    chk("next_err", 32'(err), 0);
    repeat (4) do_cmd(PREV, 2'd0, 4'h0);
    chk("prev_cursor", 32'(cursor), 0);
    chk("prev_peek", 32'(peek), 1);
    repeat (2) do_cmd(NEXT, 2'd0, 4'h0);
    chk("next2_cursor", 32'(cursor), 2);
    do_cmd(POP, 2'd0, 4'h0);
    chk("clamp_cursor", 32'(cursor), 1);
    chk("clamp_peek", 32'(peek), 2);
    chk("clamp_popd", 32'(pop_data), 3);
    do_cmd(CLR, 2'd0, 4'h0);

    do_cmd(PUSH, 2'd0, 4'h4);
    do_cmd(SWAP, 2'd0, 4'h0);
    chk("swap1_err", 32'(err), 1);
    chk("swap1_top", 32'(top), 4);
    do_cmd(PUSH, 2'd0, 4'h6);
    do_cmd(SWAP, 2'd0, 4'h0);
    chk("swap_top", 32'(top), 4);
    chk("swap_second", 32'(second), 6);
    chk("swap_err", 32'(err), 0);
    do_cmd(CLR, 2'd0, 4'h0);
    chk("clr_count", 32'(count), 0);
    chk("clr_top", 32'(top), 0);
    chk("clr_second", 32'(second), 0);
    chk("clr_peek", 32'(peek), 0);

    do_cmd(PUSH, 2'd0, 4'hA);
    do_cmd(PUSH, 2'd0, 4'hB);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = MATH;
    math_sel  = 2'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_top", 32'(top), 0);
    chk("arst_empty", 32'(empty), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd       = NOP;
    chk("arst_hold_count", 32'(count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_count", 32'(count), 0);
    do_cmd(PUSH, 2'd0, 4'h5);
    chk("post_push_count", 32'(count), 1);
    chk("post_push_top", 32'(top), 5);
    chk("post_push_second", 32'(second), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
